rf_operand_seq: RTL

- Operand-supply stage directly upstream of the ALU/register stage (A/B operand regs, ALU, F/FR result regs).
- Holds a 2^AW x DW register file; on each start it reads two source registers, presents them with the opcode, and pulses load enables for the operand and result registers.
- Writes the returned result F back to a destination register.
- Runs one 4-state sequence per operation, single clock domain.

---
 rtl/rf_operand_seq_if.sv | 36 +++
 rtl/rf_operand_seq.sv | 121 ++++++++++++
 2 files changed

// File: rtl/rf_operand_seq_if.sv
// Bus bundle between the operand sequencer and its driver/ALU stage.
// The master drives requests, external writes, the ALU result and the debug address.
interface rf_operand_seq_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          start;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
    logic [3:0]    op;
    logic          wb_en;
    logic          ext_we;
    logic [AW-1:0] ext_waddr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] F;
    logic [DW-1:0] Data_A;
    logic [DW-1:0] Data_B;
    logic [3:0]    ALU_OP;
    logic          ld_ab;
    logic          ld_f;
    logic          busy;
    logic          done;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_data;

    modport master (
        output start, rs1, rs2, rd, op, wb_en, ext_we, ext_waddr, ext_wdata, F, dbg_addr,
        input  Data_A, Data_B, ALU_OP, ld_ab, ld_f, busy, done, dbg_data
    );

    modport slave (
        input  start, rs1, rs2, rd, op, wb_en, ext_we, ext_waddr, ext_wdata, F, dbg_addr,
        output Data_A, Data_B, ALU_OP, ld_ab, ld_f, busy, done, dbg_data
    );
endinterface

// File: rtl/rf_operand_seq.sv
// Register file plus a four-state sequencer that fetches two operands, strobes the
// ALU stage load enables, and writes the returned result back to the destination.
module rf_operand_seq #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input logic             clk,
    input logic             rst,
    rf_operand_seq_if.slave bus
);
    localparam int NREG = 1 << AW;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

    state_t        state_reg, state_next;
    logic [DW-1:0] rf_reg [NREG];
    logic [DW-1:0] data_a_reg, data_b_reg;
    logic [3:0]    alu_op_reg;
    logic [AW-1:0] rd_reg;
    logic          wb_en_reg;

    logic            accept;
    logic            wb_fire;
    logic            ext_fire;
    logic [NREG-1:0] wr_en;
    logic [DW-1:0]   wr_data;

    assign accept   = (state_reg == IDLE) && bus.start;
    assign wb_fire  = (state_reg == WB) && wb_en_reg;
    assign ext_fire = (state_reg == IDLE) && bus.ext_we;
    // Write-back and external writes live in disjoint states, so one data mux suffices.
    assign wr_data  = (state_reg == WB) ? bus.F : bus.ext_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_wr_en
            if (gi == 0) begin : g_zero
                assign wr_en[gi] = 1'b0;
            end else begin : g_reg
                assign wr_en[gi] = (wb_fire  && (rd_reg        == AW'(gi))) ||
                                   (ext_fire && (bus.ext_waddr == AW'(gi)));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_en[i]) begin
                    rf_reg[i] <= wr_data;
                end
            end
        end
    end

    // Operands are sampled from the pre-edge array contents, so a same-cycle
    // external write is not visible to this fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_a_reg <= '0;
            data_b_reg <= '0;
            alu_op_reg <= '0;
            rd_reg     <= '0;
            wb_en_reg  <= 1'b0;
        end else if (accept) begin
            data_a_reg <= rf_reg[bus.rs1];
            data_b_reg <= rf_reg[bus.rs2];
            alu_op_reg <= bus.op;
            rd_reg     <= bus.rd;
            wb_en_reg  <= bus.wb_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bus.ld_ab  = 1'b0;
        bus.ld_f   = 1'b0;
        bus.done   = 1'b0;
        bus.busy   = 1'b1;
        case (state_reg)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                bus.ld_ab  = 1'b1;
                state_next = EXEC;
            end
            EXEC: begin
                bus.ld_f   = 1'b1;
                state_next = WB;
            end
            WB: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.Data_A   = data_a_reg;
    assign bus.Data_B   = data_b_reg;
    assign bus.ALU_OP   = alu_op_reg;
    assign bus.dbg_data = rf_reg[bus.dbg_addr];
endmodule
